// File: rtl/aes_req_arbiter_pkg.sv
// Shared types for the AES request arbiter: block width, FSM state encodings
// and a small one-hot helper.
package aes_req_arbiter_pkg;

    localparam int BLOCK_DATA_WIDTH = 128;
    localparam int ARB_STATE_W      = 2;
    localparam int ARB_MAX_REQ      = 8;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_ST_IDLE  = 2'b00,
        ARB_ST_ISSUE = 2'b01,
        ARB_ST_BUSY  = 2'b10,
        ARB_ST_RESP  = 2'b11
    } arb_state_e;

    function automatic logic [ARB_MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
        idx_to_onehot = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/aes_req_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping
// modulo NUM_REQ. Purely combinational.
module aes_req_arbiter_rr_pick
    import aes_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_vld,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    logic [ID_W-1:0] cand_s;

    // Scan from farthest to nearest offset so the nearest asserted request is the last write.
    always_comb begin
        cand_s  = {ID_W{1'b0}};
        winner  = {ID_W{1'b0}};
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            winner  = req_vld[cand_s] ? cand_s : winner;
            any_req = any_req | req_vld[cand_s];
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin scheduler sharing one AES-128 core among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_req_arbiter
    import aes_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_vld,
    input  logic [NUM_REQ*BLOCK_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  req_grant,
    input  logic                                core_data_accept,
    output logic [BLOCK_DATA_WIDTH-1:0]         core_block_data_in,
    output logic                                core_block_data_vld,
    input  logic [BLOCK_DATA_WIDTH-1:0]         core_data_out,
    input  logic                                core_data_out_vld,
    output logic [BLOCK_DATA_WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]                     resp_id,
    output logic                                resp_vld,
    input  logic                                resp_ready,
    output logic                                arb_err
);

    arb_state_e                  state_r;
    arb_state_e                  state_nxt_s;
    logic                        core_rdy_r;
    logic [ID_W-1:0]             rr_ptr_r;
    logic [ID_W-1:0]             cur_id_r;
    logic [ID_W-1:0]             winner_s;
    logic [ID_W-1:0]             ptr_nxt_s;
    logic                        any_req_s;
    logic [BLOCK_DATA_WIDTH-1:0] winner_data_s;
    logic [ARB_MAX_REQ-1:0]      winner_onehot_s;
    logic                        issue_s;
    logic                        capture_s;
    logic                        handshake_s;
    logic                        timeout_s;

    logic [NUM_REQ-1:0]          req_grant_r;
    logic [BLOCK_DATA_WIDTH-1:0] core_block_data_in_r;
    logic                        core_block_data_vld_r;
    logic [BLOCK_DATA_WIDTH-1:0] resp_data_r;
    logic [ID_W-1:0]             resp_id_r;
    logic                        resp_vld_r;

    aes_req_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_vld (req_vld),
        .rr_ptr  (rr_ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    assign issue_s         = (state_r == ARB_ST_IDLE) && core_rdy_r && any_req_s;
    assign capture_s       = (state_r == ARB_ST_BUSY) && core_data_out_vld;
    assign handshake_s     = (state_r == ARB_ST_RESP) && resp_vld_r && resp_ready;
    assign ptr_nxt_s       = (winner_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : winner_s + ID_W'(1);
    assign winner_onehot_s = idx_to_onehot(3'(winner_s));

    // Select the winning requester's block.
    always_comb begin
        winner_data_s = {BLOCK_DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            winner_data_s = (winner_s == ID_W'(i)) ?
                            req_data[i*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH] : winner_data_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ARB_ST_ISSUE;
                end else begin
                    state_nxt_s = ARB_ST_IDLE;
                end
            end
            ARB_ST_ISSUE: state_nxt_s = ARB_ST_BUSY;
            ARB_ST_BUSY: begin
                if (capture_s) begin
                    state_nxt_s = ARB_ST_RESP;
                end else if (timeout_s) begin
                    state_nxt_s = ARB_ST_IDLE;
                end else begin
                    state_nxt_s = ARB_ST_BUSY;
                end
            end
            ARB_ST_RESP: begin
                if (handshake_s) begin
                    state_nxt_s = ARB_ST_IDLE;
                end else begin
                    state_nxt_s = ARB_ST_RESP;
                end
            end
            default: state_nxt_s = ARB_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ARB_ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Arbitration bookkeeping, core handoff and response capture registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rdy_r            <= 1'b0;
            rr_ptr_r              <= {ID_W{1'b0}};
            cur_id_r              <= {ID_W{1'b0}};
            req_grant_r           <= {NUM_REQ{1'b0}};
            core_block_data_in_r  <= {BLOCK_DATA_WIDTH{1'b0}};
            core_block_data_vld_r <= 1'b0;
            resp_data_r           <= {BLOCK_DATA_WIDTH{1'b0}};
            resp_id_r             <= {ID_W{1'b0}};
            resp_vld_r            <= 1'b0;
        end else begin
            // An accept from the core wins over the clear so a ready pulse is never lost.
            if (core_data_accept) begin
                core_rdy_r <= 1'b1;
            end else if (state_r == ARB_ST_ISSUE) begin
                core_rdy_r <= 1'b0;
            end else if (timeout_s) begin
                core_rdy_r <= 1'b1;
            end else begin
                core_rdy_r <= core_rdy_r;
            end

            req_grant_r           <= issue_s ? NUM_REQ'(winner_onehot_s) : {NUM_REQ{1'b0}};
            core_block_data_vld_r <= (state_r == ARB_ST_ISSUE);

            if (issue_s) begin
                core_block_data_in_r <= winner_data_s;
                cur_id_r             <= winner_s;
                rr_ptr_r             <= ptr_nxt_s;
            end else begin
                core_block_data_in_r <= core_block_data_in_r;
                cur_id_r             <= cur_id_r;
                rr_ptr_r             <= rr_ptr_r;
            end

            if (capture_s) begin
                resp_data_r <= core_data_out;
                resp_id_r   <= cur_id_r;
                resp_vld_r  <= 1'b1;
            end else if (handshake_s) begin
                resp_data_r <= resp_data_r;
                resp_id_r   <= resp_id_r;
                resp_vld_r  <= 1'b0;
            end else begin
                resp_data_r <= resp_data_r;
                resp_id_r   <= resp_id_r;
                resp_vld_r  <= resp_vld_r;
            end
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    logic [6:0] tmo_cnt_r;
    logic       arb_err_r;

    assign timeout_s = (state_r == ARB_ST_BUSY) && !core_data_out_vld &&
                       (tmo_cnt_r == 7'(TIMEOUT_CYCLES - 1));

    // BUSY watchdog: restarts on BUSY entry, latches a sticky error on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= 7'd0;
            arb_err_r <= 1'b0;
        end else begin
            if (state_r == ARB_ST_ISSUE) begin
                tmo_cnt_r <= 7'd0;
            end else if (state_r == ARB_ST_BUSY) begin
                tmo_cnt_r <= tmo_cnt_r + 7'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            arb_err_r <= arb_err_r | timeout_s;
        end
    end

    assign arb_err = arb_err_r;
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
    assign arb_err          = 1'b0;
`endif

    assign req_grant           = req_grant_r;
    assign core_block_data_in  = core_block_data_in_r;
    assign core_block_data_vld = core_block_data_vld_r;
    assign resp_data           = resp_data_r;
    assign resp_id             = resp_id_r;
    assign resp_vld            = resp_vld_r;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: transaction-level reference model, behavioural
// AES core stand-in, directed scenarios and a randomized soak.
module tb_aes_req_arbiter;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int BW  = 128;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_vld = '0;
    logic [N*BW-1:0] req_data = '0;
    logic [N-1:0]    req_grant;
    logic            core_data_accept = 1'b0;
    logic [BW-1:0]   core_block_data_in;
    logic            core_block_data_vld;
    logic [BW-1:0]   core_data_out = '0;
    logic            core_data_out_vld = 1'b0;
    logic [BW-1:0]   resp_data;
    logic [IW-1:0]   resp_id;
    logic            resp_vld;
    logic            resp_ready = 1'b0;
    logic            arb_err;

    aes_req_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_vld             (req_vld),
        .req_data            (req_data),
        .req_grant           (req_grant),
        .core_data_accept    (core_data_accept),
        .core_block_data_in  (core_block_data_in),
        .core_block_data_vld (core_block_data_vld),
        .core_data_out       (core_data_out),
        .core_data_out_vld   (core_data_out_vld),
        .resp_data           (resp_data),
        .resp_id             (resp_id),
        .resp_vld            (resp_vld),
        .resp_ready          (resp_ready),
        .arb_err             (arb_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Core stand-in configuration, written by the test process only.
    int kick_req = 0;
    int lat      = 5;
    int c_mode   = 0;
    bit hang     = 1'b0;
    bit spur_en  = 1'b0;

    // Behavioural AES core: result = ~block after a latency; accept with or after done.
    int            c_cnt = 0;
    int            c_dacc = 0;
    int            kick_seen = 0;
    logic [BW-1:0] c_blk = '0;
    initial forever begin
        @(negedge clk);
        core_data_out_vld = 1'b0;
        core_data_accept  = 1'b0;
        if (kick_req != kick_seen) begin
            core_data_accept = 1'b1;
            kick_seen = kick_req;
        end
        if (c_dacc > 0) begin
            c_dacc--;
            if (c_dacc == 0) core_data_accept = 1'b1;
        end
        if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0) begin
                core_data_out_vld = 1'b1;
                core_data_out     = ~c_blk;
                if (c_mode == 0 || $urandom_range(0, 1) == 0) core_data_accept = 1'b1;
                else c_dacc = $urandom_range(1, 4);
            end
        end
        if (core_block_data_vld && !hang) begin
            c_blk = core_block_data_in;
            c_cnt = (c_mode == 0) ? lat : $urandom_range(1, 12);
        end
        if (spur_en && c_cnt == 0 && !core_data_out_vld && $urandom_range(0, 15) == 0) begin
            core_data_out_vld = 1'b1;
            core_data_out     = {$urandom, $urandom, $urandom, $urandom};
        end
        if (spur_en && $urandom_range(0, 31) == 0) core_data_accept = 1'b1;
    end

    // Reference model: tracks one transaction (granted / in core / awaiting handshake).
    bit            m_rdy, m_granted, m_waiting, m_holding, m_err;
    bit            m_g0, m_w0, m_h0, m_tmo;
    int            m_ptr, m_id, m_busy_n, m_win;
    logic [N-1:0]  e_grant = '0;
    logic          e_start = 1'b0;
    logic [BW-1:0] e_bdin = '0, e_rdata = '0;
    logic [IW-1:0] e_rid = '0;
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_rdy = 0; m_granted = 0; m_waiting = 0; m_holding = 0; m_err = 0;
            m_ptr = 0; m_id = 0; m_busy_n = 0;
            e_grant = '0; e_start = 1'b0; e_bdin = '0; e_rdata = '0; e_rid = '0;
        end else begin
            m_g0 = m_granted; m_w0 = m_waiting; m_h0 = m_holding; m_tmo = 0;
            e_grant = '0;
            e_start = 1'b0;
            if (!m_g0 && !m_w0 && !m_h0 && m_rdy && req_vld != '0) begin
                m_win = -1;
                for (int k = 0; k < N; k++)
                    if (m_win < 0 && req_vld[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                e_grant[m_win] = 1'b1;
                e_bdin    = req_data[m_win*BW +: BW];
                m_id      = m_win;
                m_ptr     = (m_win + 1) % N;
                m_granted = 1;
            end
            if (m_g0) begin
                e_start = 1'b1; m_granted = 0; m_waiting = 1; m_busy_n = 0;
            end
            if (m_w0) begin
                if (core_data_out_vld) begin
                    e_rdata = core_data_out; e_rid = IW'(m_id);
                    m_waiting = 0; m_holding = 1;
                end else begin
                    m_busy_n++;
`ifdef AES_ARB_TIMEOUT_EN
                    if (m_busy_n == TMO) begin
                        m_tmo = 1; m_err = 1; m_waiting = 0;
                    end
`endif
                end
            end
            if (m_h0 && resp_ready) m_holding = 0;
            if (core_data_accept) m_rdy = 1;
            else if (m_g0) m_rdy = 0;
            else if (m_tmo) m_rdy = 1;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        chk("req_grant", req_grant, e_grant);
        chk("core_block_data_vld", core_block_data_vld, e_start);
        chk("core_block_data_in", core_block_data_in, e_bdin);
        chk("resp_vld", resp_vld, m_holding);
        chk("resp_data", resp_data, e_rdata);
        chk("resp_id", resp_id, e_rid);
        chk("arb_err", arb_err, m_err);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, ng, nr, seen, hid;
        int g_ord[5];
        int r_ord[5];
        int exp_ord[5];
        logic [BW-1:0] held;
        logic [BW-1:0] blk1;
        exp_ord = '{0, 1, 2, 3, 0};
        blk1 = 128'h00112233_44556677_8899aabb_ccddeeff;

        repeat (3) @(negedge clk);
        chk("rst_grant", req_grant, 0);
        chk("rst_start", core_block_data_vld, 0);
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_err", arb_err, 0);
        reset = 1'b0;

        // No core accept yet: requests must not be granted.
        req_vld = 4'b1111;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (req_grant != '0 || core_block_data_vld) seen = 1;
        end
        chk("t4_no_grant", seen, 0);

        // Single request from requester 1.
        req_vld = 4'b0010;
        req_data[1*BW +: BW] = blk1;
        lat = 5;
        kick_req++;
        n = 0;
        while (req_grant == '0 && n < 20) begin @(negedge clk); n++; end
        chk("t1_grant", req_grant, 4'b0010);
        req_vld = '0;
        @(negedge clk);
        chk("t1_start", core_block_data_vld, 1);
        chk("t1_block", core_block_data_in, blk1);
        n = 0;
        while (!resp_vld && n < 30) begin @(negedge clk); n++; end
        chk("t1_latency", n, 6);
        chk("t1_resp_id", resp_id, 1);
        chk("t1_resp_data", resp_data, 128'hffeeddcc_bbaa9988_77665544_33221100);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // All four requesting, 40-cycle core: rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*BW +: BW] = {4{32'h1111_0000 + 32'(i)}};
        req_vld = 4'b1111;
        resp_ready = 1'b1;
        lat = 40;
        kick_req++;
        ng = 0; nr = 0; n = 0;
        while (nr < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (req_grant != '0 && ng < 5) begin g_ord[ng] = oh2i(req_grant); ng++; end
            if (resp_vld && resp_ready) begin r_ord[nr] = int'(resp_id); nr++; end
        end
        chk("t2_resp_count", nr, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_grant_%0d", i), g_ord[i], exp_ord[i]);
            chk($sformatf("t2_resp_%0d", i), r_ord[i], exp_ord[i]);
        end
        @(negedge clk);

        // Stalled response: held stable, no new grant.
        resp_ready = 1'b0;
        lat = 5;
        n = 0;
        while (!resp_vld && n < 100) begin @(negedge clk); n++; end
        held = resp_data;
        hid  = int'(resp_id);
        chk("t3_id", hid, 1);
        seen = 0; ng = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_vld !== 1'b1 || resp_data !== held || int'(resp_id) != hid) seen = 1;
            if (req_grant != '0) ng = 1;
        end
        chk("t3_stable", seen, 0);
        chk("t3_no_grant", ng, 0);
        req_vld = '0;
        resp_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Reset while the core is busy.
        do_reset();
        lat = 10;
        req_vld = 4'b0001;
        kick_req++;
        n = 0;
        while (!core_block_data_vld && n < 20) begin @(negedge clk); n++; end
        chk("t5_started", core_block_data_vld, 1);
        req_vld = '0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_grant", req_grant, 0);
        chk("t5_start", core_block_data_vld, 0);
        chk("t5_block", core_block_data_in, 0);
        chk("t5_resp_vld", resp_vld, 0);
        chk("t5_resp_data", resp_data, 0);
        chk("t5_resp_id", resp_id, 0);
        chk("t5_err", arb_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_vld) seen = 1;
        end
        chk("t5_no_resp", seen, 0);

        // Randomized soak.
        do_reset();
        c_mode  = 1;
        spur_en = 1'b1;
        kick_req++;
        repeat (3000) begin
            @(negedge clk);
            req_vld    = N'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0)
                    req_data[i*BW +: BW] = {$urandom, $urandom, $urandom, $urandom};
        end
        req_vld    = '0;
        resp_ready = 1'b1;
        spur_en    = 1'b0;
        c_mode     = 0;
        repeat (30) @(negedge clk);

`ifdef AES_ARB_TIMEOUT_EN
        // Core never finishes: watchdog fires after 64 BUSY cycles.
        do_reset();
        hang = 1'b1;
        req_vld = 4'b0001;
        kick_req++;
        n = 0;
        while (!core_block_data_vld && n < 20) begin @(negedge clk); n++; end
        req_vld = '0;
        n = 0;
        while (!arb_err && n < 200) begin @(negedge clk); n++; end
        chk("t6_err", arb_err, 1);
        chk("t6_cycles", n, TMO);
        hang = 1'b0;
        req_vld = 4'b0010;
        n = 0;
        while (req_grant == '0 && n < 10) begin @(negedge clk); n++; end
        chk("t6_regrant", req_grant, 4'b0010);
        req_vld = '0;
        repeat (30) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
